// File: rtl/stopwatch_pkg.sv
// rtl/stopwatch_pkg.sv - shared state encoding, 7-seg glyphs and sizing helper for the stopwatch
package stopwatch_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_LAP   = 2'd3
    } sw_state_t;

    // Active-low segments, bit order gfedcba
    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    // Bits needed to hold values 0..value-1 (at least 1)
    function automatic int sw_clog2(input int value);
        int bits;
        int rem;
        bits = 0;
        rem  = value - 1;
        while (rem > 0) begin
            bits = bits + 1;
            rem  = rem >> 1;
        end
        return (bits < 1) ? 1 : bits;
    endfunction

endpackage

// File: rtl/stopwatch_bcd_seg7_decoder.sv
// rtl/stopwatch_bcd_seg7_decoder.sv - combinational BCD to active-low 7-segment decoder
module seg7_decoder
    import stopwatch_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [6:0] seg
);

    // Standard glyphs for 0-9; anything else blanks the digit
    always_comb begin
        seg = SEG_BLANK;
        case (bcd)
            4'd0: seg = SEG_0;
            4'd1: seg = SEG_1;
            4'd2: seg = SEG_2;
            4'd3: seg = SEG_3;
            4'd4: seg = SEG_4;
            4'd5: seg = SEG_5;
            4'd6: seg = SEG_6;
            4'd7: seg = SEG_7;
            4'd8: seg = SEG_8;
            4'd9: seg = SEG_9;
            default: seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/stopwatch_bcd.sv
// rtl/stopwatch_bcd.sv - start/stop/lap BCD stopwatch driving DE-board HEX and LEDR
module stopwatch_bcd
    import stopwatch_pkg::*;
#(
    parameter int CLK_HZ    = 50_000_000,
    parameter int TICK_HZ   = 100,
    parameter int DIGITS    = 4,
    parameter int WRAP_MODE = 1,
    parameter int DB_CYCLES = 500_000
) (
    input  logic                  CLOCK_50,
    input  logic [3:0]            KEY,
    output logic [7*DIGITS-1:0]   HEX,
    output logic [2:0]            LEDR
);

    localparam int DIV   = CLK_HZ / TICK_HZ;
    localparam int PSC_W = sw_clog2(DIV);
    localparam int DB_W  = sw_clog2(DB_CYCLES + 1);

    logic                  rst_meta;
    logic                  rst_n;
    logic [2:0]            press;
    sw_state_t             state;
    sw_state_t             state_nxt;
    logic                  do_snap;
    logic                  do_clear;
    logic                  psc_zero;
    logic                  running;
    logic                  tick;
    logic [PSC_W-1:0]      psc;
    logic [4*DIGITS-1:0]   count;
    logic [4*DIGITS-1:0]   snap;
    logic [4*DIGITS-1:0]   disp_val;
    logic [DIGITS:0]       carry;
    logic                  all9;
    logic                  ovf;
    logic [1:0]            led_q;

    // Reset asserts immediately from KEY[0], releases two clocks later
    always_ff @(posedge CLOCK_50 or negedge KEY[0]) begin
        if (!KEY[0]) begin
            rst_meta <= 1'b0;
            rst_n    <= 1'b0;
        end else begin
            rst_meta <= 1'b1;
            rst_n    <= rst_meta;
        end
    end

    // press[0]=start/stop (KEY[1]), press[1]=lap (KEY[2]), press[2]=clear (KEY[3])
    for (genvar k = 0; k < 3; k++) begin : g_key
        logic            sync0;
        logic            sync1;
        logic [DB_W-1:0] db_cnt;
        logic            pulse;

        // Synchronise the button, count consecutive low cycles, pulse once on the DB_CYCLES-th
        always_ff @(posedge CLOCK_50 or negedge rst_n) begin
            if (!rst_n) begin
                sync0  <= 1'b1;
                sync1  <= 1'b1;
                db_cnt <= '0;
                pulse  <= 1'b0;
            end else begin
                sync0 <= KEY[k+1];
                sync1 <= sync0;
                if (sync1)
                    db_cnt <= '0;
                else if (db_cnt != DB_W'(DB_CYCLES))
                    db_cnt <= db_cnt + 1'b1;
                pulse <= !sync1 && (db_cnt == DB_W'(DB_CYCLES - 1));
            end
        end

        assign press[k] = pulse;
    end

    // Run-control state register
    always_ff @(posedge CLOCK_50 or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    // Next state with clear > start > lap priority
    always_comb begin
        state_nxt = state;
        do_snap   = 1'b0;
        do_clear  = 1'b0;
        psc_zero  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (press[2]) begin
                    do_clear = 1'b1;
                end else if (press[0]) begin
                    state_nxt = ST_RUN;
                    psc_zero  = 1'b1;
                end
            end
            ST_RUN: begin
                if (press[0]) begin
                    state_nxt = ST_PAUSE;
                end else if (press[1]) begin
                    state_nxt = ST_LAP;
                    do_snap   = 1'b1;
                end
            end
            ST_LAP: begin
                if (press[0])      state_nxt = ST_PAUSE;
                else if (press[1]) do_snap   = 1'b1;
            end
            ST_PAUSE: begin
                if (press[2]) begin
                    state_nxt = ST_IDLE;
                    do_clear  = 1'b1;
                end else if (press[0]) begin
                    state_nxt = ST_RUN;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    assign running = (state == ST_RUN) || (state == ST_LAP);
    assign tick    = running && (psc == PSC_W'(DIV - 1));

    // Prescaler advances only while counting, so a pause keeps the fractional tick
    always_ff @(posedge CLOCK_50 or negedge rst_n) begin
        if (!rst_n)                   psc <= '0;
        else if (psc_zero || do_clear) psc <= '0;
        else if (running)             psc <= tick ? '0 : psc + 1'b1;
    end

    assign carry[0] = 1'b1;
    assign all9     = carry[DIGITS];

    for (genvar i = 0; i < DIGITS; i++) begin : g_digit
        logic [3:0] digit_q;
        logic [6:0] seg;
        logic [6:0] hex_q;

        assign carry[i+1]     = carry[i] && (digit_q == 4'd9);
        assign count[4*i +: 4] = digit_q;

        // Digit steps when every lower digit is 9; saturating mode freezes at all-9s
        always_ff @(posedge CLOCK_50 or negedge rst_n) begin
            if (!rst_n)
                digit_q <= '0;
            else if (do_clear)
                digit_q <= '0;
            else if (tick && carry[i] && !(all9 && (WRAP_MODE == 0)))
                digit_q <= (digit_q == 4'd9) ? 4'd0 : digit_q + 4'd1;
        end

        seg7_decoder u_dec (
            .bcd (disp_val[4*i +: 4]),
            .seg (seg)
        );

        // Registered segment drive
        always_ff @(posedge CLOCK_50 or negedge rst_n) begin
            if (!rst_n) hex_q <= SEG_0;
            else        hex_q <= seg;
        end

        assign HEX[7*i +: 7] = hex_q;
    end

    // Lap snapshot of the live count
    always_ff @(posedge CLOCK_50 or negedge rst_n) begin
        if (!rst_n)        snap <= '0;
        else if (do_clear) snap <= '0;
        else if (do_snap)  snap <= count;
    end

    // Sticky overflow on a tick at all-9s
    always_ff @(posedge CLOCK_50 or negedge rst_n) begin
        if (!rst_n)            ovf <= 1'b0;
        else if (do_clear)     ovf <= 1'b0;
        else if (tick && all9) ovf <= 1'b1;
    end

    // Registered run/lap indicators
    always_ff @(posedge CLOCK_50 or negedge rst_n) begin
        if (!rst_n) led_q <= 2'b00;
        else        led_q <= {state == ST_LAP, running};
    end

    assign disp_val = (state == ST_LAP) ? snap : count;
    assign LEDR     = {ovf, led_q};

endmodule

// File: tb/tb_stopwatch_bcd.sv
// tb/tb_stopwatch_bcd.sv - scoreboard bench for stopwatch_bcd in wrap and saturate modes
module tb_stopwatch_bcd;

    localparam int CLK_HZ    = 1000;
    localparam int TICK_HZ   = 100;
    localparam int DIGITS    = 2;
    localparam int DB_CYCLES = 2;
    localparam int DIV       = CLK_HZ / TICK_HZ;
    localparam int MAXV      = 99;
    localparam int M_IDLE    = 0;
    localparam int M_RUN     = 1;
    localparam int M_PAUSE   = 2;
    localparam int M_LAP     = 3;

    logic                CLOCK_50 = 1'b0;
    logic [3:0]          KEY      = 4'b1110;
    logic [7*DIGITS-1:0] hex_w;
    logic [7*DIGITS-1:0] hex_s;
    logic [2:0]          ledr_w;
    logic [2:0]          ledr_s;

    typedef struct {
        logic [13:0] hex_w;
        logic [13:0] hex_s;
        logic [2:0]  led;
    } exp_t;

    exp_t exp_q[$];
    int   vectors     = 0;
    int   miscompares = 0;
    int   cycle       = 0;

    always #5 CLOCK_50 = ~CLOCK_50;

    stopwatch_bcd #(.CLK_HZ(CLK_HZ), .TICK_HZ(TICK_HZ), .DIGITS(DIGITS),
                    .WRAP_MODE(1), .DB_CYCLES(DB_CYCLES)) dut_wrap (
        .CLOCK_50 (CLOCK_50),
        .KEY      (KEY),
        .HEX      (hex_w),
        .LEDR     (ledr_w)
    );

    stopwatch_bcd #(.CLK_HZ(CLK_HZ), .TICK_HZ(TICK_HZ), .DIGITS(DIGITS),
                    .WRAP_MODE(0), .DB_CYCLES(DB_CYCLES)) dut_sat (
        .CLOCK_50 (CLOCK_50),
        .KEY      (KEY),
        .HEX      (hex_s),
        .LEDR     (ledr_s)
    );

    function automatic logic [6:0] glyph(input int d);
        case (d)
            0: return 7'b1000000;
            1: return 7'b1111001;
            2: return 7'b0100100;
            3: return 7'b0110000;
            4: return 7'b0011001;
            5: return 7'b0010010;
            6: return 7'b0000010;
            7: return 7'b1111000;
            8: return 7'b0000000;
            9: return 7'b0010000;
            default: return 7'b1111111;
        endcase
    endfunction

    function automatic logic [13:0] show(input int v);
        return {glyph(v / 10), glyph(v % 10)};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s cycle %0d actual %h required %h", name, cycle, act, req);
        end
    endtask

    // Reference model state: stopwatch time in whole ticks and cycles into the current tick
    int       hi_cnt   = 0;
    int       mode     = M_IDLE;
    int       phase    = 0;
    int       cnt_w    = 0;
    int       cnt_s    = 0;
    int       snap_w   = 0;
    int       snap_s   = 0;
    int       disp_w   = 0;
    int       disp_s   = 0;
    bit       ovf      = 1'b0;
    bit [1:0] led_prev = 2'b00;
    int       lowrun[3];
    bit [2:0] dl[3];

    task automatic model_reset();
        mode     = M_IDLE;
        phase    = 0;
        cnt_w    = 0;
        cnt_s    = 0;
        snap_w   = 0;
        snap_s   = 0;
        disp_w   = 0;
        disp_s   = 0;
        ovf      = 1'b0;
        led_prev = 2'b00;
        for (int k = 0; k < 3; k++) begin
            lowrun[k] = 0;
            dl[k]     = 3'b000;
        end
    endtask

    task automatic model_clear();
        cnt_w  = 0;
        cnt_s  = 0;
        snap_w = 0;
        snap_s = 0;
        ovf    = 1'b0;
        phase  = 0;
    endtask

    always @(posedge CLOCK_50) begin : model
        bit [2:0] eff;
        bit       running;
        bit       tick;
        int       old_w;
        int       old_s;
        exp_t     e;
        cycle++;
        if (!KEY[0] || hi_cnt < 2) begin
            if (!KEY[0]) hi_cnt = 0;
            else         hi_cnt++;
            model_reset();
            e.hex_w = show(0);
            e.hex_s = show(0);
            e.led   = 3'b000;
        end else begin
            for (int k = 0; k < 3; k++) begin
                eff[k] = dl[k][2];
                dl[k]  = {dl[k][1:0], 1'b0};
                if (KEY[k+1]) begin
                    lowrun[k] = 0;
                end else if (lowrun[k] < DB_CYCLES) begin
                    lowrun[k]++;
                    if (lowrun[k] == DB_CYCLES) dl[k][0] = 1'b1;
                end
            end
            running = (mode == M_RUN) || (mode == M_LAP);
            tick    = 1'b0;
            if (running) begin
                if (phase == DIV - 1) begin
                    tick  = 1'b1;
                    phase = 0;
                end else begin
                    phase++;
                end
            end
            old_w = cnt_w;
            old_s = cnt_s;
            if (tick) begin
                if (cnt_w == MAXV) begin
                    cnt_w = 0;
                    ovf   = 1'b1;
                end else begin
                    cnt_w++;
                end
                if (cnt_s < MAXV) cnt_s++;
            end
            case (mode)
                M_IDLE: begin
                    if (eff[2]) model_clear();
                    else if (eff[0]) begin
                        mode  = M_RUN;
                        phase = 0;
                    end
                end
                M_RUN: begin
                    if (eff[0]) mode = M_PAUSE;
                    else if (eff[1]) begin
                        mode   = M_LAP;
                        snap_w = old_w;
                        snap_s = old_s;
                    end
                end
                M_LAP: begin
                    if (eff[0]) mode = M_PAUSE;
                    else if (eff[1]) begin
                        snap_w = old_w;
                        snap_s = old_s;
                    end
                end
                default: begin
                    if (eff[2]) begin
                        mode = M_IDLE;
                        model_clear();
                    end else if (eff[0]) begin
                        mode = M_RUN;
                    end
                end
            endcase
            e.hex_w  = show(disp_w);
            e.hex_s  = show(disp_s);
            e.led    = {ovf, led_prev};
            disp_w   = (mode == M_LAP) ? snap_w : cnt_w;
            disp_s   = (mode == M_LAP) ? snap_s : cnt_s;
            led_prev = {mode == M_LAP, (mode == M_RUN) || (mode == M_LAP)};
        end
        exp_q.push_back(e);
    end

    always @(negedge CLOCK_50) begin : monitor
        exp_t m;
        if (exp_q.size() > 0) begin
            m = exp_q.pop_front();
            check("hex_wrap", 32'(hex_w), 32'(m.hex_w));
            check("hex_sat", 32'(hex_s), 32'(m.hex_s));
            check("ledr_wrap", 32'(ledr_w), 32'(m.led));
            check("ledr_sat", 32'(ledr_s), 32'(m.led));
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge CLOCK_50);
    endtask

    task automatic press(input int k, input int len);
        @(negedge CLOCK_50);
        KEY[k] = 1'b0;
        repeat (len) @(negedge CLOCK_50);
        KEY[k] = 1'b1;
    endtask

    task automatic async_reset_check(input string name);
        @(negedge CLOCK_50);
        #1;
        KEY[0] = 1'b0;
        #1;
        check({name, "_hex_wrap"}, 32'(hex_w), 32'(show(0)));
        check({name, "_hex_sat"}, 32'(hex_s), 32'(show(0)));
        check({name, "_ledr_wrap"}, 32'(ledr_w), 32'd0);
        check({name, "_ledr_sat"}, 32'(ledr_s), 32'd0);
        cyc(3);
        KEY[0] = 1'b1;
        cyc(6);
    endtask

    initial begin
        cyc(3);
        check("reset_hex", 32'(hex_w), 32'(show(0)));
        check("reset_ledr", 32'(ledr_w), 32'd0);
        KEY[0] = 1'b1;
        cyc(6);

        // start, run to 37 and on through overflow
        press(1, 2 + $urandom_range(0, 3));
        cyc(10 * 37 + $urandom_range(0, 20));
        cyc(700 + $urandom_range(0, 50));

        // pause a few cycles after a tick, hold, resume
        press(1, 2);
        cyc(500);
        press(1, 3);
        cyc(100 + $urandom_range(0, 30));

        // lap, re-lap, then stop
        press(2, 2);
        cyc(180);
        press(2, 2);
        cyc(50);
        press(1, 2);
        cyc(30);

        // clear ignored while running, honoured while paused
        press(1, 2);
        cyc(40);
        press(3, 2);
        cyc(40);
        press(1, 2);
        cyc(20);
        press(3, 2);
        cyc(20);

        // clear and start together while paused
        press(1, 2);
        cyc(60);
        press(1, 2);
        cyc(10);
        @(negedge CLOCK_50);
        KEY[1] = 1'b0;
        KEY[3] = 1'b0;
        cyc(2);
        KEY[1] = 1'b1;
        KEY[3] = 1'b1;
        cyc(20);

        // single-cycle bounce
        press(1, 1);
        cyc(20);

        // random key traffic, including bounces and chords
        repeat (60) begin
            if ($urandom_range(0, 7) == 0) begin
                @(negedge CLOCK_50);
                KEY[1] = 1'b0;
                KEY[$urandom_range(2, 3)] = 1'b0;
                cyc($urandom_range(1, 4));
                KEY[3:1] = 3'b111;
            end else begin
                press($urandom_range(1, 3), $urandom_range(1, 4));
            end
            cyc($urandom_range(5, 120));
        end

        // asynchronous reset while running at 47
        async_reset_check("areset_a");
        press(1, 2);
        cyc(10 * 47 + 4);
        async_reset_check("areset_b");

        cyc(5);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
